// File: rtl/bnw_pkg.sv
// Shared constants and the judge state encoding for the block-and-key game lanes.
package bnw_pkg;

  localparam int unsigned H_W         = 10;
  localparam int unsigned COMBO_W     = 7;
  localparam int unsigned OFF_H       = 720;
  localparam int unsigned SPAWN_H     = 120;
  localparam int unsigned HIT_LO_DEF  = 600;
  localparam int unsigned HIT_HI_DEF  = 680;
  localparam int unsigned MISS_H_DEF  = 700;
  localparam int unsigned PERF_LO_DEF = 630;
  localparam int unsigned PERF_HI_DEF = 650;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    JUDGED = 2'd2
  } judge_state_e;

  function automatic logic in_range(input logic [H_W-1:0] h,
                                    input logic [H_W-1:0] lo,
                                    input logic [H_W-1:0] hi);
    return (h >= lo) && (h <= hi);
  endfunction

endpackage

// File: rtl/lane_hit_judge_rise_edge.sv
// Rising-edge detector: registers a level and flags the cycle it goes high.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_c_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign rise_c_o = sig_i & ~sig_q;

endmodule

// File: rtl/lane_hit_judge.sv
// Per-lane hit/miss judge with saturating score, combo and max combo.
// Define JUDGE_PERFECT_EN to add the double-point perfect window and its pulse output.
module lane_hit_judge
  import bnw_pkg::*;
#(
  parameter int unsigned HIT_LO  = HIT_LO_DEF,
  parameter int unsigned HIT_HI  = HIT_HI_DEF,
  parameter int unsigned MISS_H  = MISS_H_DEF,
  parameter int unsigned SCORE_W = 16
`ifdef JUDGE_PERFECT_EN
  ,
  parameter int unsigned PERF_LO = PERF_LO_DEF,
  parameter int unsigned PERF_HI = PERF_HI_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               stop_or_endgame,
  input  logic [H_W-1:0]     block_h,
  input  logic               key_in,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo
`ifdef JUDGE_PERFECT_EN
  ,
  output logic               perfect
`endif
);

  localparam logic [H_W-1:0] HIT_LO_H = H_W'(HIT_LO);
  localparam logic [H_W-1:0] HIT_HI_H = H_W'(HIT_HI);
  localparam logic [H_W-1:0] MISS_H_H = H_W'(MISS_H);
  localparam logic [H_W-1:0] OFF_H_H  = H_W'(OFF_H);

  judge_state_e         state_q;
  logic [H_W-1:0]       prev_h_q;
  logic                 hit_q;
  logic                 miss_q;
  logic [SCORE_W-1:0]   score_q;
  logic [COMBO_W-1:0]   combo_q;
  logic [COMBO_W-1:0]   max_combo_q;

  logic                 rst_any_c;
  logic                 press_c;
  logic                 spawn_c;
  logic                 in_win_c;
  logic [1:0]           score_inc_c;
  logic [SCORE_W:0]     score_sum_c;
  logic [SCORE_W-1:0]   score_d;
  logic [COMBO_W-1:0]   combo_d;

  assign rst_any_c = rst | restart;

  rise_edge u_key_edge (
    .clk      (clk),
    .rst      (rst_any_c),
    .sig_i    (key_in),
    .rise_c_o (press_c)
  );

  // Previous height tracks even while paused so a pause cannot fake a spawn.
  always_ff @(posedge clk) begin
    if (rst_any_c) prev_h_q <= OFF_H_H;
    else           prev_h_q <= block_h;
  end

  assign spawn_c  = block_h < prev_h_q;
  assign in_win_c = in_range(block_h, HIT_LO_H, HIT_HI_H);

`ifdef JUDGE_PERFECT_EN
  localparam logic [H_W-1:0] PERF_LO_H = H_W'(PERF_LO);
  localparam logic [H_W-1:0] PERF_HI_H = H_W'(PERF_HI);
  logic in_perf_c;
  logic perfect_q;

  assign in_perf_c   = in_range(block_h, PERF_LO_H, PERF_HI_H);
  assign score_inc_c = in_perf_c ? 2'd2 : 2'd1;

  always_ff @(posedge clk) begin
    if (rst_any_c || stop_or_endgame) perfect_q <= 1'b0;
    else perfect_q <= (state_q == ACTIVE) && press_c && in_win_c && in_perf_c;
  end

  assign perfect = perfect_q;
`else
  assign score_inc_c = 2'd1;
`endif

  assign score_sum_c = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(score_inc_c);
  assign score_d     = score_sum_c[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_c[SCORE_W-1:0];
  // A re-spawn zeroes the combo before the new block's hit counts.
  assign combo_d     = spawn_c ? COMBO_W'(1) : ((&combo_q) ? combo_q : combo_q + COMBO_W'(1));

  always_ff @(posedge clk) begin
    if (rst_any_c) begin
      state_q     <= IDLE;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
    end else if (stop_or_endgame) begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (spawn_c || (block_h < OFF_H_H)) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (spawn_c) begin
            miss_q  <= 1'b1;
            combo_q <= '0;
          end
          if (press_c) begin
            state_q <= JUDGED;
            if (in_win_c) begin
              hit_q   <= 1'b1;
              score_q <= score_d;
              combo_q <= combo_d;
              if (combo_d > max_combo_q) max_combo_q <= combo_d;
            end else begin
              miss_q  <= 1'b1;
              combo_q <= '0;
            end
          end else if (block_h >= MISS_H_H) begin
            state_q <= JUDGED;
            miss_q  <= 1'b1;
            combo_q <= '0;
          end
        end
        JUDGED: begin
          if (spawn_c)                   state_q <= ACTIVE;
          else if (block_h >= OFF_H_H)   state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign combo     = combo_q;
  assign max_combo = max_combo_q;

endmodule
